// File: rtl/edge_event_monitor_if.sv
// Event stream carrying detected edges from the monitor to its consumer.
// Ports: ev_valid/ev_ready handshake, ev_kind (01 rising, 10 falling), ev_time (timestamp).
// master = event producer (monitor), slave = event consumer.
interface edge_event_monitor_if #(
   parameter int TSW = 16
);
   logic           ev_valid;
   logic           ev_ready;
   logic [1:0]     ev_kind;
   logic [TSW-1:0] ev_time;

   modport master (
      output ev_valid,
      output ev_kind,
      output ev_time,
      input  ev_ready
   );

   modport slave (
      input  ev_valid,
      input  ev_kind,
      input  ev_time,
      output ev_ready
   );
endinterface

// File: rtl/edge_event_monitor.sv
// Timestamped edge detector on a synchronous signal feeding a small event FIFO.
// Latency: an edge sampled at posedge N is visible at the FIFO head right after posedge N.
// Backpressure: consumer stalls via ev_ready; a full FIFO without a pop drops the new event
// and sets the sticky overflow flag.
// Ports: clk, rst (sync, active-high), sig (monitored), en (record enable),
//        ev (event stream, master side), count (stored events), overflow (sticky drop flag).
module edge_event_monitor #(
   parameter int DEPTH = 4,
   parameter int TSW   = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       sig,
   input  logic                       en,
   edge_event_monitor_if.master       ev,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       overflow
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic           prev;
   logic           armed;
   logic [TSW-1:0] tstamp;

   logic [1:0]     mem_kind [DEPTH];
   logic [TSW-1:0] mem_time [DEPTH];
   logic [PW-1:0]  wr_ptr;
   logic [PW-1:0]  rd_ptr;
   logic [CW-1:0]  count_q;
   logic           overflow_q;

   logic           edge_det;
   logic           not_empty;
   logic           full;
   logic           pop;
   logic           push;
   logic           drop;
   logic [1:0]     new_kind;

   // The very first sample after reset only seeds prev; comparing against the
   // reset value of prev would report a fake edge.
   assign edge_det  = armed && en && (sig != prev);
   assign new_kind  = {~sig, sig};
   assign not_empty = (count_q != '0);
   assign full      = (count_q == FULL);
   assign pop       = not_empty && ev.ev_ready;
   // A pop in the same cycle frees the slot the incoming event needs.
   assign push      = edge_det && (!full || pop);
   assign drop      = edge_det && full && !pop;

   always_ff @(posedge clk) begin
      if (rst) begin
         prev   <= 1'b0;
         armed  <= 1'b0;
         tstamp <= '0;
      end else begin
         prev   <= sig;
         armed  <= 1'b1;
         tstamp <= tstamp + TSW'(1);
      end
   end

   // Storage needs no reset: entries are only read while count says they are valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_kind[wr_ptr] <= new_kind;
         mem_time[wr_ptr] <= tstamp;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
         if (drop) begin
            overflow_q <= 1'b1;
         end
      end
   end

   assign ev.ev_valid = not_empty;
   assign ev.ev_kind  = not_empty ? mem_kind[rd_ptr] : 2'b00;
   assign ev.ev_time  = not_empty ? mem_time[rd_ptr] : '0;
   assign count       = count_q;
   assign overflow    = overflow_q;

endmodule

// File: doc/edge_event_monitor.md
EDGE_EVENT_MONITOR -- requirements
Module: edge_event_monitor

Interface
REQ-001 Parameter DEPTH, default 4, event FIFO entries (power of two, >= 2).
REQ-002 Parameter TSW, default 16, timestamp width in bits.
REQ-003 clk  in  1  sole clock; all state updates on posedge clk.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 sig  in  1  monitored signal, sampled on posedge clk, already synchronous to clk.
REQ-006 en  in  1  edge detection enable; when low, edges are tracked but not recorded.
REQ-007 ev_valid  out  1  FIFO head holds an event.
REQ-008 ev_ready  in  1  consumer accepts the head event when high together with ev_valid.
REQ-009 ev_kind  out  2  head event type: 2'b01 rising, 2'b10 falling, never 00 or 11 while ev_valid is high.
REQ-010 ev_time  out  TSW  timestamp of the head event.
REQ-011 count  out  $clog2(DEPTH+1)  number of stored events, 0..DEPTH.
REQ-012 overflow  out  1  sticky flag: at least one event was dropped.

Function
REQ-013 prev register holds sig as sampled at the previous posedge; armed flag is 0 after reset and is set at the first posedge after reset, when prev captures sig without generating an event.
REQ-014 Free-running timestamp counter tstamp: 0 after reset, +1 every posedge, wraps 2^TSW-1 -> 0 with no flag.
REQ-015 Edge detected at posedge N when armed=1, en=1 and sig != prev; kind = rising if sig=1, falling if sig=0.
REQ-016 Recorded ev_time = tstamp value before posedge N, which is the cycle count of the sample that showed the new level.
REQ-017 prev updates every posedge regardless of en, so an edge occurring while en=0 is never reported later.
REQ-018 Push occurs at posedge N; when the FIFO was empty, ev_valid is high in the cycle immediately after posedge N (1-cycle latency).
REQ-019 Pop occurs at a posedge where ev_valid=1 and ev_ready=1; ev_kind and ev_time advance to the next entry in the same update.
REQ-020 ev_ready while ev_valid=0 has no effect; count never underflows.
REQ-021 Push and pop in the same cycle with 0 < count < DEPTH: both happen and count is unchanged.
REQ-022 Full (count=DEPTH) with pop in the same cycle: pop frees a slot, push is accepted, count stays DEPTH, overflow is unchanged.
REQ-023 Full without pop: new event dropped, FIFO contents unchanged, overflow set to 1 and held until reset.
REQ-024 FIFO order is strictly first-in first-out; read and write pointers wrap modulo DEPTH.
REQ-025 ev_kind and ev_time are 0 while ev_valid=0.

Reset
REQ-026 At posedge with rst=1: count=0, ev_valid=0, ev_kind=0, ev_time=0, overflow=0, tstamp=0, armed=0, prev=0, pointers=0.
REQ-027 Reset mid-operation discards all stored events and any edge sampled in the reset cycle; an in-progress handshake is abandoned with no pop reported.
REQ-028 First detectable edge after reset release is at the second posedge with rst=0, because the first posedge arms.

Verification
REQ-029 Reset; sig=0, en=1; raise sig for tstamp=5 sample -> one event kind=01 time=5, ev_valid high next cycle, count=1.
REQ-030 Toggle sig 1,0,1 on consecutive cycles with ev_ready=0, DEPTH=4 -> count=3, popped in order kinds 01,10,01 with times t,t+1,t+2.
REQ-031 Produce 5 edges with ev_ready=0 -> count=4, overflow=1, first 4 events retained, 5th lost; overflow stays 1 after draining.
REQ-032 FIFO full, ev_ready=1 in the same cycle as a new edge -> count stays 4, overflow=0, new event appears last.
REQ-033 en=0 during a rising edge, en=1 afterwards with sig steady -> no event; a next falling edge is reported as 10.
REQ-034 Assert rst with count=3 and sig=1 held -> count=0, ev_valid=0; after release, the arming cycle produces no event even though sig=1 differs from reset prev=0.
